mem_wb_elastic_reg: RTL and testbench
=====================================

# mem_wb_elastic_reg

Parametrised, elastic MEM→WB pipeline register. It carries the memory-stage result bundle (write-back enable, load flag, ALU result, load data, destination register) into write-back. It uses a valid/ready handshake, a synchronous flush, an optional 2-entry skid buffer for full throughput under back-pressure, and a pre-muxed write-back value. It sits between the data-memory stage and the register-file write port and replaces the fixed-width, always-advancing MEM stage register.

## Interface
Parameters:
- DATA_W, 32: width of ALU result, load data and write-back value.
- DEST_W, 4: width of destination register index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle.
- WB_EN_IN  in  1  bundle writes the register file.
- MEM_R_EN_IN  in  1  bundle is a load.
- ALU_result_in  in  DATA_W  ALU result / address.
- mem_read_value_in  in  DATA_W  load data.
- Dest_in  in  DEST_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  write-back accepts the head entry.
- WB_EN  out  1  head write-back enable, gated by out_valid.
- MEM_R_EN  out  1  head load flag.
- ALU_result  out  DATA_W  head ALU result.
- mem_read_value  out  DATA_W  head load data.
- Dest  out  DEST_W  head destination.
- wb_value  out  DATA_W  MEM_R_EN ? mem_read_value : ALU_result (combinational from head).

## Operation
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - head register (main) plus skid register, each with its own valid bit.
  - Occupancy states: EMPTY (no valid), ONE (head valid), TWO (head and skid valid).
- Transitions when flush = 0:
  - EMPTY: in_fire → ONE, head ← input.
  - ONE:
    - in_fire & out_fire → ONE, head ← input.
    - in_fire & !out_fire → TWO, skid ← input.
    - out_fire only → EMPTY.
    - Otherwise hold.
  - TWO: in_ready = 0. out_fire → ONE, head ← skid; otherwise hold.
- Flush has priority over every handshake:
  - Both valid bits are cleared, next state is EMPTY.
  - An in_fire in the same cycle is dropped.
  - Payload registers hold their values; they are don't-care.
- Output gating:
  - WB_EN = head.wb_en & out_valid. No register-file write can come from an invalid head.
  - Other payload outputs are don't-care while out_valid = 0, but are never X after reset.
- wb_value is a pure mux on head fields; it adds no register stage.
- Arithmetic: none. All fields pass through width-exact, with no extension or truncation.

## Timing
- Reset (synchronous, rst high at posedge):
  - out_valid = 0, WB_EN = 0, MEM_R_EN = 0.
  - ALU_result, mem_read_value, Dest = 0; wb_value = 0.
  - Skid valid = 0, so in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards both entries; in-flight bundles are lost.
- Latency: a bundle accepted at edge N appears at the head after edge N (out_valid = 1 in cycle N+1).
- Throughput: 1 bundle/cycle when out_ready is held high.
- in_ready is a registered output, equal to !skid_valid. It has no combinational path from out_ready.
- Upstream must hold its bundle stable while in_valid & !in_ready.
- Head entries leave in order. The skid entry never bypasses the head.

## Configuration
- MEM_WB_SKID_EN defined:
  - 2-entry behaviour as above.
  - in_ready is registered, giving full throughput under back-pressure.
- Not defined:
  - Skid register is removed; only the EMPTY and ONE states exist.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire & out_fire in ONE replaces the head.
  - Flush, reset and output gating are unchanged.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 → out_valid = 0, WB_EN = 0, Dest = 0, in_ready = 1 after release.
- Streaming: out_ready = 1, send 4 bundles with Dest = 1..4 and ALU_result = 0x10..0x13 on back-to-back cycles → each appears one cycle later, in order, no bubbles; wb_value = ALU_result when MEM_R_EN = 0.
- Load mux: MEM_R_EN_IN = 1, ALU_result_in = 0x100, mem_read_value_in = 0xDEADBEEF → wb_value = 0xDEADBEEF.
- Back-pressure, MEM_WB_SKID_EN defined: out_ready = 0, send A then B → in_ready drops after B, head = A. Raise out_ready → A then B retire on consecutive cycles, nothing lost or duplicated.
- Flush: with state TWO, assert flush together with in_valid = 1 and Dest_in = 7 → next cycle out_valid = 0, WB_EN = 0, in_ready = 1, bundle 7 never appears.
- Macro off: out_ready = 0 while head valid → in_ready = 0 in the same cycle. Raise out_ready with in_valid = 1 → head is replaced in one cycle.

Source files
------------

// File: rtl/mem_wb_elastic_reg.sv
// Elastic MEM->WB pipeline register: valid/ready handshake, synchronous flush, pre-muxed write-back value.
// Optional feature macro MEM_WB_SKID_EN adds a skid entry so in_ready can be registered.
module mem_wb_elastic_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] mem_read_value_in,
    input  logic [DEST_W-1:0] Dest_in,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] mem_read_value,
    output logic [DEST_W-1:0] Dest,
    output logic [DATA_W-1:0] wb_value
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mrd;
        logic [DEST_W-1:0] dest;
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    occ_e    state_q, state_d;
    bundle_t head_q, head_d;
    bundle_t in_bundle;
    logic    in_fire, out_fire;

`ifdef MEM_WB_SKID_EN
    bundle_t skid_q, skid_d;
    logic    rdy_q, rdy_d;
`endif

    assign in_bundle = '{wb_en: WB_EN_IN, mem_r: MEM_R_EN_IN, alu: ALU_result_in,
                         mrd: mem_read_value_in, dest: Dest_in};

    assign out_valid = (state_q != S_EMPTY);

    always_comb begin
`ifdef MEM_WB_SKID_EN
        in_ready = rdy_q;
`else
        // Without a skid slot the head can only take a new bundle if it is leaving.
        in_ready = (state_q == S_EMPTY) | out_ready;
`endif
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;

        state_d  = state_q;
        head_d   = head_q;
`ifdef MEM_WB_SKID_EN
        skid_d   = skid_q;
`endif

        if (flush) begin
            // Payload is left alone; only occupancy is dropped, including any same-cycle in_fire.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d = S_ONE;
                        head_d  = in_bundle;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = in_bundle;
                    end else if (in_fire) begin
`ifdef MEM_WB_SKID_EN
                        state_d = S_TWO;
                        skid_d  = in_bundle;
`endif
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
`ifdef MEM_WB_SKID_EN
                    if (out_fire) begin
                        state_d = S_ONE;
                        head_d  = skid_q;
                    end
`else
                    state_d = S_EMPTY;
`endif
                end
                default: state_d = S_EMPTY;
            endcase
        end

`ifdef MEM_WB_SKID_EN
        rdy_d = (state_d != S_TWO);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
`ifdef MEM_WB_SKID_EN
            skid_q  <= '0;
            rdy_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
`ifdef MEM_WB_SKID_EN
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
`endif
        end
    end

    // A stale head must never reach the register-file write port.
    assign WB_EN          = head_q.wb_en & out_valid;
    assign MEM_R_EN       = head_q.mem_r;
    assign ALU_result     = head_q.alu;
    assign mem_read_value = head_q.mrd;
    assign Dest           = head_q.dest;
    assign wb_value       = head_q.mem_r ? head_q.mrd : head_q.alu;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Self-checking bench for mem_wb_elastic_reg: directed steps plus random traffic against a queue model.
module tb_mem_wb_elastic_reg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 4;
`ifdef MEM_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic              wb_en;
        logic              mem_r;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mrd;
        logic [DEST_W-1:0] dest;
    } bnd_t;

    logic clk, rst, flush, in_valid, out_ready;
    logic in_ready, out_valid, WB_EN, MEM_R_EN;
    logic [DATA_W-1:0] ALU_result, mem_read_value, wb_value;
    logic [DEST_W-1:0] Dest;
    bnd_t drv;

    int errs = 0;
    int checks = 0;
    bnd_t q[$];
    bit stalled = 0;

    mem_wb_elastic_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .WB_EN_IN(drv.wb_en), .MEM_R_EN_IN(drv.mem_r),
        .ALU_result_in(drv.alu), .mem_read_value_in(drv.mrd), .Dest_in(drv.dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .mem_read_value(mem_read_value), .Dest(Dest), .wb_value(wb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    // Compare outputs against the model, then advance both one clock.
    task automatic step();
        bit rdy, ifire, ofire;
        bnd_t cur;
        #1;
        rdy = model_ready();
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("WB_EN", 64'(WB_EN), 64'((q.size() > 0) ? q[0].wb_en : 1'b0));
        if (q.size() > 0) begin
            chk("MEM_R_EN", 64'(MEM_R_EN), 64'(q[0].mem_r));
            chk("ALU_result", 64'(ALU_result), 64'(q[0].alu));
            chk("mem_read_value", 64'(mem_read_value), 64'(q[0].mrd));
            chk("Dest", 64'(Dest), 64'(q[0].dest));
            chk("wb_value", 64'(wb_value), 64'(q[0].mem_r ? q[0].mrd : q[0].alu));
        end
        ifire = in_valid && rdy;
        ofire = (q.size() > 0) && out_ready;
        stalled = in_valid && !rdy;
        cur = drv;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(cur);
        end
        @(negedge clk);
    endtask

    function automatic bnd_t mk(input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] m, input logic lr);
        bnd_t b;
        b.wb_en = 1'b1; b.mem_r = lr; b.alu = a; b.mrd = m; b.dest = d;
        return b;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1;
        drv = mk(4'd9, 32'h55, 32'h66, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_WB_EN", 64'(WB_EN), 64'd0);
        chk("rst_MEM_R_EN", 64'(MEM_R_EN), 64'd0);
        chk("rst_Dest", 64'(Dest), 64'd0);
        chk("rst_ALU_result", 64'(ALU_result), 64'd0);
        chk("rst_mem_read_value", 64'(mem_read_value), 64'd0);
        chk("rst_wb_value", 64'(wb_value), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            drv = mk(DEST_W'(i + 1), 32'h10 + 32'(i), 32'hA0 + 32'(i), 1'b0);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Load mux.
        in_valid = 1'b1;
        drv = mk(4'd5, 32'h100, 32'hDEADBEEF, 1'b1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        chk("load_wb_value", 64'(wb_value), 64'hDEADBEEF);
        step();
        out_ready = 1'b1;
        step();
        step();

`ifdef MEM_WB_SKID_EN
        // Back-pressure: A then B, then drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; drv = mk(4'd10, 32'hA, 32'h0, 1'b0); step();
        drv = mk(4'd11, 32'hB, 32'h0, 1'b0); step();
        in_valid = 1'b0;
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_dest", 64'(Dest), 64'd10);
        step();
        out_ready = 1'b1;
        step();
        #1;
        chk("bp_second_dest", 64'(Dest), 64'd11);
        step();
        step();

        // Flush in TWO with a concurrent input.
        out_ready = 1'b0;
        in_valid = 1'b1; drv = mk(4'd1, 32'h1, 32'h0, 1'b0); step();
        drv = mk(4'd2, 32'h2, 32'h0, 1'b0); step();
        flush = 1'b1; drv = mk(4'd7, 32'h7, 32'h0, 1'b0); step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_WB_EN", 64'(WB_EN), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        step();
`else
        // Combinational in_ready, head replacement.
        out_ready = 1'b0;
        in_valid = 1'b1; drv = mk(4'd3, 32'h33, 32'h0, 1'b0); step();
        in_valid = 1'b0;
        #1;
        chk("nos_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1; in_valid = 1'b1; drv = mk(4'd4, 32'h44, 32'h0, 1'b0);
        #1;
        chk("nos_in_ready_high", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("nos_replaced_dest", 64'(Dest), 64'd4);
        // Flush with a concurrent input.
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; drv = mk(4'd7, 32'h7, 32'h0, 1'b0); step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_WB_EN", 64'(WB_EN), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step();
`endif

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                drv.wb_en = 1'($urandom());
                drv.mem_r = 1'($urandom());
                drv.alu = $urandom();
                drv.mrd = $urandom();
                drv.dest = DEST_W'($urandom());
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
